// File: rtl/lyapunov_engine_if.sv
// -----------------------------------------------------------------------------
// lyapunov_engine_if
// Pixel request/result bundle between the pixel scanner, the Lyapunov engine
// and the colour mapper.
//   iStart    : start request, a rising edge launches one pixel run
//   iX, iY    : pixel coordinates selecting r_A / r_B
//   iS        : A/B switching sequence (bit k = 1 selects r_B)
//   oBusy     : run in progress
//   oCalc_end : one-cycle pulse when oLambda has just been updated
//   oLambda   : signed averaged log2 derivative, LF fraction bits
// Modports: master = requester (scanner side), slave = engine.
// -----------------------------------------------------------------------------
interface lyapunov_engine_if #(
    parameter int CW    = 8,
    parameter int S_LEN = 2,
    parameter int ACC_W = 64
);
    logic                    iStart;
    logic [CW-1:0]           iX;
    logic [CW-1:0]           iY;
    logic [S_LEN-1:0]        iS;
    logic                    oBusy;
    logic                    oCalc_end;
    logic signed [ACC_W-1:0] oLambda;

    modport master (
        output iStart, iX, iY, iS,
        input  oBusy, oCalc_end, oLambda
    );

    modport slave (
        input  iStart, iX, iY, iS,
        output oBusy, oCalc_end, oLambda
    );
endinterface

// File: rtl/lyapunov_engine.sv
// -----------------------------------------------------------------------------
// lyapunov_engine
// Fixed-point Lyapunov exponent of the logistic map x' = r*x*(1-x) for one
// pixel, r alternating between r_A (from iX) and r_B (from iY) as dictated by
// the sequence iS. The first WARMUP iterations are discarded, the next
// 2^LOG2_ITER log2|f'(x)| terms are summed and averaged.
// Ports:
//   iCLK   : clock
//   iRST_N : asynchronous active-low reset
//   bus    : lyapunov_engine_if.slave (iStart/iX/iY/iS in, oBusy/oCalc_end/
//            oLambda out; all outputs are registered)
// Formats: x Q0.FW, r/t/d Q2.FW, log terms and oLambda Q(ACC_W-LF).LF.
// -----------------------------------------------------------------------------
module lyapunov_engine #(
    parameter int CW        = 8,
    parameter int FW        = 16,
    parameter int S_LEN     = 2,
    parameter int LOG2_ITER = 6,
    parameter int WARMUP    = 8,
    parameter int LF        = 8,
    parameter int ACC_W     = 64
) (
    input logic               iCLK,
    input logic               iRST_N,
    lyapunov_engine_if.slave  bus
);
    localparam int RW    = FW + 2;                 // Q2.FW operand width
    localparam int MW    = FW + 1;                 // width able to hold 1.0
    localparam int TOTAL = WARMUP + (1 << LOG2_ITER);
    localparam int KW    = $clog2(TOTAL + 1);
    localparam int SW    = (S_LEN > 1) ? $clog2(S_LEN) : 1;
    localparam int LW    = $clog2(RW);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CALC_A = 3'd2,
        S_CALC_B = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_start_q;
    logic                    w_start;

    logic [RW-1:0]           r_ra;
    logic [RW-1:0]           r_rb;
    logic [S_LEN-1:0]        r_seq;
    logic [FW-1:0]           r_x;
    logic [RW-1:0]           r_t;
    logic [RW-1:0]           r_d;
    logic [KW-1:0]           r_k;
    logic [SW-1:0]           r_sidx;
    logic                    r_accum_en;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_busy;
    logic                    r_calc_end;
    logic signed [ACC_W-1:0] r_lambda;

    logic [RW-1:0]           w_r;
    logic [RW+FW-1:0]        w_prod_t;
    logic [RW-1:0]           w_t;
    logic [MW-1:0]           w_one;
    logic [MW-1:0]           w_two_x;
    logic [MW-1:0]           w_m;
    logic [RW+MW-1:0]        w_prod_d;
    logic [RW-1:0]           w_d;
    logic [MW-1:0]           w_one_minus_x;
    logic [RW+MW-1:0]        w_prod_x;
    logic [FW-1:0]           w_x_next;
    logic [LW-1:0]           w_lead;
    logic [RW+LF-1:0]        w_norm;
    logic [LF-1:0]           w_frac;
    logic [ACC_W-1:0]        w_term;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [KW-1:0]           w_k_next;
    logic                    w_last;
    logic [SW-1:0]           w_sidx_next;
    logic                    w_unused;

    assign w_start = bus.iStart & ~r_start_q;

    assign bus.oBusy     = r_busy;
    assign bus.oCalc_end = r_calc_end;
    assign bus.oLambda   = r_lambda;

    // Delayed copy of iStart for rising-edge detection
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= bus.iStart;
        end
    end

    // FSM state register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; start edges outside IDLE are ignored
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = w_start ? S_LOAD : S_IDLE;
            S_LOAD:   w_state_next = S_CALC_A;
            S_CALC_A: w_state_next = S_CALC_B;
            S_CALC_B: w_state_next = w_last ? S_DONE : S_CALC_A;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Iteration arithmetic: products are truncated, never rounded
    always_comb begin
        w_r           = r_seq[r_sidx] ? r_rb : r_ra;
        w_prod_t      = (RW+FW)'(w_r) * (RW+FW)'(r_x);
        w_t           = w_prod_t[RW+FW-1:FW];
        w_one         = {1'b1, {FW{1'b0}}};
        w_two_x       = {r_x, 1'b0};
        if (w_two_x >= w_one) begin
            w_m = w_two_x - w_one;
        end else begin
            w_m = w_one - w_two_x;
        end
        w_prod_d      = (RW+MW)'(w_r) * (RW+MW)'(w_m);
        // r < 4 and |1-2x| <= 1, so d always fits in Q2.FW
        w_d           = w_prod_d[FW+RW-1:FW];
        w_one_minus_x = w_one - {1'b0, r_x};
        w_prod_x      = (RW+MW)'(r_t) * (RW+MW)'(w_one_minus_x);
        // r*x*(1-x) < 1, so only the FW fraction bits carry information
        w_x_next      = w_prod_x[2*FW-1:FW];
    end

    // log2 term from d: exponent from the leading one, mantissa bits below it
    always_comb begin
        w_lead = '0;
        for (int i = 0; i < RW; i++) begin
            w_lead = r_d[i] ? LW'(i) : w_lead;
        end
        // Left-align the leading one; the LF zero bits pad short mantissas
        w_norm = {r_d, {LF{1'b0}}} << (LW'(RW - 1) - w_lead);
        w_frac = w_norm[RW+LF-2 -: LF];
        if (r_d == '0) begin
            w_term = ACC_W'(0) - (ACC_W'(FW) << LF);
        end else begin
            w_term = ((ACC_W'(w_lead) - ACC_W'(FW)) << LF) + ACC_W'(w_frac);
        end
        if (r_accum_en) begin
            w_acc_next = r_acc + $signed(w_term);
        end else begin
            w_acc_next = r_acc;
        end
    end

    // Iteration and sequence-position bookkeeping
    always_comb begin
        w_k_next = r_k + KW'(1);
        w_last   = (w_k_next == KW'(TOTAL));
        if (r_sidx == SW'(S_LEN - 1)) begin
            w_sidx_next = '0;
        end else begin
            w_sidx_next = r_sidx + SW'(1);
        end
    end

    // Bits of the wide products that carry no result
    assign w_unused = ^{w_prod_t[FW-1:0], w_prod_d[FW-1:0], w_prod_d[RW+MW-1],
                        w_prod_x[FW-1:0], w_prod_x[RW+MW-1:2*FW],
                        w_norm[RW+LF-1], w_norm[RW-2:0]};

    // Datapath and registered outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_ra       <= '0;
            r_rb       <= '0;
            r_seq      <= '0;
            r_x        <= '0;
            r_t        <= '0;
            r_d        <= '0;
            r_k        <= '0;
            r_sidx     <= '0;
            r_accum_en <= 1'b0;
            r_acc      <= '0;
            r_busy     <= 1'b0;
            r_calc_end <= 1'b0;
            r_lambda   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_calc_end <= 1'b0;
                    // Raised on entry so oBusy is already high during LOAD
                    if (w_start) begin
                        r_busy <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_ra       <= {2'b10, {FW{1'b0}}} + (RW'(bus.iX) << (FW + 1 - CW));
                    r_rb       <= {2'b10, {FW{1'b0}}} + (RW'(bus.iY) << (FW + 1 - CW));
                    r_seq      <= bus.iS;
                    r_x        <= {1'b1, {(FW-1){1'b0}}};
                    r_acc      <= '0;
                    r_k        <= '0;
                    r_sidx     <= '0;
                    r_accum_en <= (WARMUP == 0);
                end
                S_CALC_A: begin
                    r_t <= w_t;
                    r_d <= w_d;
                end
                S_CALC_B: begin
                    r_x    <= w_x_next;
                    r_acc  <= w_acc_next;
                    r_k    <= w_k_next;
                    r_sidx <= w_sidx_next;
                    // Accumulation starts with iteration index WARMUP
                    if (w_k_next == KW'(WARMUP)) begin
                        r_accum_en <= 1'b1;
                    end else begin
                        r_accum_en <= r_accum_en;
                    end
                    // Result and pulse are registered so both appear in DONE
                    if (w_last) begin
                        r_lambda   <= w_acc_next >>> LOG2_ITER;
                        r_calc_end <= 1'b1;
                    end else begin
                        r_calc_end <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_calc_end <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_calc_end <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lyapunov_engine.sv
// -----------------------------------------------------------------------------
// tb_lyapunov_engine
// Directed bench for lyapunov_engine: a default-parameter instance plus a
// second instance (S_LEN=3, LOG2_ITER=4, WARMUP=0) fed with the same pixel.
// Fixed-point cases use hand-computed values; chaotic pixels are compared
// against a bit-accurate behavioural model of the iteration.
// -----------------------------------------------------------------------------
module tb_lyapunov_engine;
    logic iCLK;
    logic iRST_N;

    int n_cmp;
    int n_err;

    int          lat, pulses, lat2, pulses2;
    logic        busy1;
    logic [63:0] lam, lam2;

    lyapunov_engine_if #(.CW(8), .S_LEN(2), .ACC_W(64)) bus ();
    lyapunov_engine_if #(.CW(8), .S_LEN(3), .ACC_W(64)) bus2 ();

    assign bus2.iStart = bus.iStart;
    assign bus2.iX     = bus.iX;
    assign bus2.iY     = bus.iY;
    assign bus2.iS     = {1'b0, bus.iS};

    lyapunov_engine u_dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    lyapunov_engine #(.S_LEN(3), .LOG2_ITER(4), .WARMUP(0)) u_dut_sweep (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus2)
    );

    // 100 MHz clock
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk_equal(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    // Bit-accurate model for the default parameter set (FW=16, LF=8, WARMUP=8, N=64)
    function automatic longint lyap_model(input int ix, input int iy, input logic [1:0] s);
        longint ra, rb, r, x, t, m, d, term, acc, f;
        int p;
        ra  = 131072 + (longint'(ix) << 9);
        rb  = 131072 + (longint'(iy) << 9);
        x   = 32768;
        acc = 0;
        for (int k = 0; k < 72; k++) begin
            r = s[k % 2] ? rb : ra;
            t = (r * x) >>> 16;
            m = 65536 - 2 * x;
            if (m < 0) m = -m;
            d = (r * m) >>> 16;
            x = ((t * (65536 - x)) >>> 16) & 65535;
            if (d == 0) begin
                term = -4096;
            end else begin
                p = 0;
                for (int i = 0; i < 18; i++) if (d[i]) p = i;
                if (p >= 8) f = (d >>> (p - 8)) & 255;
                else        f = (d << (8 - p)) & 255;
                term = longint'(p - 16) * 256 + f;
            end
            if (k >= 8) acc = acc + term;
        end
        return acc >>> 6;
    endfunction

    // One run: iStart high for the first `hold` edges (plus a second edge at
    // edge 20 when reedge), inputs scrambled after LOAD when scramble is set.
    task automatic run_pixel(input int hold, input bit reedge, input bit scramble, input int window);
        lat = 0; pulses = 0; lat2 = 0; pulses2 = 0; lam = '0; lam2 = '0; busy1 = 1'b0;
        @(negedge iCLK);
        bus.iStart = 1'b1;
        for (int n = 1; n <= window; n++) begin
            @(posedge iCLK);
            #1;
            if (n == 1) busy1 = bus.oBusy;
            if (bus.oCalc_end) begin
                pulses++;
                if (lat == 0) begin lat = n; lam = bus.oLambda; end
            end
            if (bus2.oCalc_end) begin
                pulses2++;
                if (lat2 == 0) begin lat2 = n; lam2 = bus2.oLambda; end
            end
            bus.iStart = ((n + 1) <= hold) || (reedge && (n + 1) >= 20 && (n + 1) < 22);
            if (scramble && n == 3) begin
                bus.iX = '0; bus.iY = 8'd77; bus.iS = 2'b10;
            end
        end
        bus.iStart = 1'b0;
    endtask

    initial begin
        longint expv;
        n_cmp = 0; n_err = 0;
        iRST_N = 1'b0;
        bus.iStart = 1'b0; bus.iX = '0; bus.iY = '0; bus.iS = 2'b01;

        // Reset held with iStart toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge iCLK); bus.iStart = ~bus.iStart;
        end
        @(posedge iCLK); #1;
        chk_equal("rst_busy", 64'(bus.oBusy), 64'd0);
        chk_equal("rst_calc_end", 64'(bus.oCalc_end), 64'd0);
        chk_equal("rst_lambda", bus.oLambda, 64'd0);
        @(negedge iCLK); bus.iStart = 1'b0;
        @(negedge iCLK); iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);

        // r = 2 fixed point: d = 0 every iteration -> -16.0
        bus.iX = 8'd0; bus.iY = 8'd0; bus.iS = 2'b01;
        run_pixel(1, 1'b0, 1'b0, 200);
        chk_equal("fix_busy_load", 64'(busy1), 64'd1);
        chk_equal("fix_latency", 64'(lat), 64'd146);
        chk_equal("fix_pulses", 64'(pulses), 64'd1);
        chk_equal("fix_lambda", lam, -64'sd4096);
        chk_equal("fix_busy_after", 64'(bus.oBusy), 64'd0);
        chk_equal("fix_hold", bus.oLambda, -64'sd4096);
        chk_equal("sweep_latency", 64'(lat2), 64'd34);
        chk_equal("sweep_pulses", 64'(pulses2), 64'd1);
        chk_equal("sweep_lambda", lam2, -64'sd4096);

        // Chaotic region, inputs changed after LOAD must not matter
        bus.iX = 8'd255; bus.iY = 8'd255; bus.iS = 2'b01;
        expv = lyap_model(255, 255, 2'b01);
        run_pixel(1, 1'b0, 1'b1, 200);
        chk_equal("chaos_latency", 64'(lat), 64'd146);
        chk_equal("chaos_pulses", 64'(pulses), 64'd1);
        chk_equal("chaos_lambda", lam, 64'(expv));
        chk_equal("chaos_sign", 64'(lam[63]), 64'd0);

        // Mixed A/B sequence
        bus.iX = 8'd200; bus.iY = 8'd40; bus.iS = 2'b10;
        expv = lyap_model(200, 40, 2'b10);
        run_pixel(1, 1'b0, 1'b0, 200);
        chk_equal("mix_lambda", lam, 64'(expv));

        // Level start held 10 cycles -> one run only
        bus.iX = 8'd0; bus.iY = 8'd0; bus.iS = 2'b01;
        run_pixel(10, 1'b0, 1'b0, 200);
        chk_equal("level_pulses", 64'(pulses), 64'd1);
        chk_equal("level_lambda", lam, -64'sd4096);

        // Second edge while busy is ignored
        run_pixel(1, 1'b1, 1'b0, 320);
        chk_equal("reedge_pulses", 64'(pulses), 64'd1);
        chk_equal("reedge_latency", 64'(lat), 64'd146);

        // Reset during iteration 30 aborts without a pulse
        @(negedge iCLK); bus.iStart = 1'b1;
        @(posedge iCLK); #1; bus.iStart = 1'b0;
        repeat (60) @(posedge iCLK);
        @(negedge iCLK); iRST_N = 1'b0;
        #1;
        chk_equal("abort_busy", 64'(bus.oBusy), 64'd0);
        chk_equal("abort_lambda", bus.oLambda, 64'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge iCLK); #1;
            if (bus.oCalc_end) pulses++;
        end
        @(negedge iCLK); iRST_N = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge iCLK); #1;
            if (bus.oCalc_end) pulses++;
        end
        chk_equal("abort_no_pulse", 64'(pulses), 64'd0);
        run_pixel(1, 1'b0, 1'b0, 200);
        chk_equal("restart_latency", 64'(lat), 64'd146);
        chk_equal("restart_lambda", lam, -64'sd4096);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
